// File: rtl/seed_random_1_card_dealer_pkg.sv
// Shared constants, FSM encoding, card payload and seed reduction for the card dealer.
package seed_random_1_card_dealer_pkg;

   localparam int unsigned DECK_SIZE      = 52;
   localparam int unsigned SEED_W         = 8;
   localparam int unsigned CARD_W         = 6;
   localparam int unsigned RANKS_PER_SUIT = 13;
   localparam int unsigned FACE_POINTS    = 10;
   localparam int unsigned SEED_BOUND     = 2 * DECK_SIZE;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PROBE   = 2'd1,
      ST_DELIVER = 2'd2
   } state_e;

   typedef struct packed {
      logic [CARD_W-1:0] id;
      logic [3:0]        rank;
      logic [1:0]        suit;
      logic [3:0]        points;
   } card_t;

   // Fold the 0..103 counter range onto a deck index; anything larger starts at 0.
   function automatic logic [CARD_W-1:0] reduce_seed(input logic [SEED_W-1:0] seed);
      if (seed < SEED_W'(DECK_SIZE)) begin
         return CARD_W'(seed);
      end else if (seed < SEED_W'(SEED_BOUND)) begin
         return CARD_W'(seed - SEED_W'(DECK_SIZE));
      end else begin
         return '0;
      end
   endfunction

endpackage

// File: rtl/seed_random_1_card_dealer_decode.sv
// Combinational card decode: id -> rank (1..13), suit (0..3), blackjack points.
module seed_random_1_card_decode
   import seed_random_1_card_dealer_pkg::*;
(
   input  logic [CARD_W-1:0] card_id_i,
   output card_t             card_c
);

   logic [CARD_W-1:0] base;
   logic [1:0]        suit;
   logic [3:0]        rank;

   always_comb begin
      suit = 2'd0;
      base = '0;
      if (card_id_i >= CARD_W'(3 * RANKS_PER_SUIT)) begin
         suit = 2'd3;
         base = CARD_W'(3 * RANKS_PER_SUIT);
      end else if (card_id_i >= CARD_W'(2 * RANKS_PER_SUIT)) begin
         suit = 2'd2;
         base = CARD_W'(2 * RANKS_PER_SUIT);
      end else if (card_id_i >= CARD_W'(RANKS_PER_SUIT)) begin
         suit = 2'd1;
         base = CARD_W'(RANKS_PER_SUIT);
      end
      rank = 4'(card_id_i - base + CARD_W'(1));
      card_c.id     = card_id_i;
      card_c.rank   = rank;
      card_c.suit   = suit;
      card_c.points = (rank > 4'(FACE_POINTS)) ? 4'(FACE_POINTS) : rank;
   end

endmodule

// File: rtl/seed_random_1_card_dealer.sv
// Card dealer: seeded linear probe over a dealt bitmap, one card per request.
// Optional burn-card behaviour enabled by SEED_RANDOM_1_DEALER_BURN_EN.
module seed_random_1_card_dealer
   import seed_random_1_card_dealer_pkg::*;
(
   input  logic              clk_cd_i,
   input  logic              rst_cd_i,
   input  logic [SEED_W-1:0] seed_idx_i,
   input  logic              draw_req_i,
   input  logic              shuffle_req_i,
   output logic              card_valid_o,
   output logic [CARD_W-1:0] card_id_o,
   output logic [3:0]        card_rank_o,
   output logic [1:0]        card_suit_o,
   output logic [3:0]        card_points_o,
   output logic              busy_o,
   output logic              deck_empty_o,
   output logic [CARD_W-1:0] cards_left_o,
   output logic              draw_err_o
);

   state_e                 state_q, state_d;
   logic [DECK_SIZE-1:0]   bitmap_q, bitmap_d;
   logic [CARD_W-1:0]      ptr_q, ptr_d;
   logic [CARD_W-1:0]      left_q, left_d;
   card_t                  card_q, card_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;
   logic                   busy_q, busy_d;
   logic                   shuf_pend_q, shuf_pend_d;
   logic [CARD_W-1:0]      ptr_next;
   card_t                  dec_c;
`ifdef SEED_RANDOM_1_DEALER_BURN_EN
   logic                   burn_pend_q, burn_pend_d;
   logic                   burning_q, burning_d;
`endif

   seed_random_1_card_decode u_decode (
      .card_id_i (ptr_q),
      .card_c    (dec_c)
   );

   assign ptr_next = (ptr_q == CARD_W'(DECK_SIZE - 1)) ? '0 : ptr_q + CARD_W'(1);

   always_ff @(posedge clk_cd_i) begin
      if (rst_cd_i) begin
         state_q     <= ST_IDLE;
         bitmap_q    <= '0;
         ptr_q       <= '0;
         left_q      <= CARD_W'(DECK_SIZE);
         card_q      <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         shuf_pend_q <= 1'b0;
`ifdef SEED_RANDOM_1_DEALER_BURN_EN
         burn_pend_q <= 1'b1;
         burning_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bitmap_q    <= bitmap_d;
         ptr_q       <= ptr_d;
         left_q      <= left_d;
         card_q      <= card_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         shuf_pend_q <= shuf_pend_d;
`ifdef SEED_RANDOM_1_DEALER_BURN_EN
         burn_pend_q <= burn_pend_d;
         burning_q   <= burning_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      bitmap_d    = bitmap_q;
      ptr_d       = ptr_q;
      left_d      = left_q;
      card_d      = card_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      shuf_pend_d = shuf_pend_q;
`ifdef SEED_RANDOM_1_DEALER_BURN_EN
      burn_pend_d = burn_pend_q;
      burning_d   = burning_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // Shuffle has priority; a coincident draw is dropped.
            if (shuffle_req_i || shuf_pend_q) begin
               bitmap_d    = '0;
               left_d      = CARD_W'(DECK_SIZE);
               shuf_pend_d = 1'b0;
`ifdef SEED_RANDOM_1_DEALER_BURN_EN
               burn_pend_d = 1'b1;
`endif
            end else if (draw_req_i) begin
               if (left_q == '0) begin
                  err_d = 1'b1;
               end else begin
                  ptr_d   = reduce_seed(seed_idx_i);
                  state_d = ST_PROBE;
`ifdef SEED_RANDOM_1_DEALER_BURN_EN
                  burning_d   = burn_pend_q && (left_q >= CARD_W'(2));
                  burn_pend_d = 1'b0;
`endif
               end
            end
         end
         ST_PROBE: begin
            if (shuffle_req_i) shuf_pend_d = 1'b1;
            if (!bitmap_q[ptr_q]) begin
               bitmap_d[ptr_q] = 1'b1;
               left_d          = (left_q == '0) ? '0 : left_q - CARD_W'(1);
`ifdef SEED_RANDOM_1_DEALER_BURN_EN
               if (burning_q) begin
                  burning_d = 1'b0;
                  ptr_d     = ptr_next;
               end else begin
                  card_d  = dec_c;
                  valid_d = 1'b1;
                  state_d = ST_DELIVER;
               end
`else
               card_d  = dec_c;
               valid_d = 1'b1;
               state_d = ST_DELIVER;
`endif
            end else begin
               ptr_d = ptr_next;
            end
         end
         ST_DELIVER: begin
            if (shuffle_req_i) shuf_pend_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   assign card_valid_o  = valid_q;
   assign card_id_o     = card_q.id;
   assign card_rank_o   = card_q.rank;
   assign card_suit_o   = card_q.suit;
   assign card_points_o = card_q.points;
   assign busy_o        = busy_q;
   assign cards_left_o  = left_q;
   assign deck_empty_o  = (left_q == '0);
   assign draw_err_o    = err_q;

endmodule

// File: tb/tb_seed_random_1_card_dealer.sv
// Scoreboard bench for the card dealer: directed draws queue expected cards, a monitor checks deliveries.
module tb_seed_random_1_card_dealer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] seed = 8'd0;
   logic       draw = 1'b0;
   logic       shuffle = 1'b0;
   logic       card_valid_o;
   logic [5:0] card_id_o;
   logic [3:0] card_rank_o;
   logic [1:0] card_suit_o;
   logic [3:0] card_points_o;
   logic       busy_o;
   logic       deck_empty_o;
   logic [5:0] cards_left_o;
   logic       draw_err_o;

   typedef struct {
      int id;
      int rank;
      int suit;
      int pts;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   seed_random_1_card_dealer dut (
      .clk_cd_i      (clk),
      .rst_cd_i      (rst),
      .seed_idx_i    (seed),
      .draw_req_i    (draw),
      .shuffle_req_i (shuffle),
      .card_valid_o  (card_valid_o),
      .card_id_o     (card_id_o),
      .card_rank_o   (card_rank_o),
      .card_suit_o   (card_suit_o),
      .card_points_o (card_points_o),
      .busy_o        (busy_o),
      .deck_empty_o  (deck_empty_o),
      .cards_left_o  (cards_left_o),
      .draw_err_o    (draw_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: every delivered card must match the oldest queued expectation.
   always @(negedge clk) begin
      if (card_valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_card_valid", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("card_id", int'(card_id_o), mon_e.id);
            check("card_rank", int'(card_rank_o), mon_e.rank);
            check("card_suit", int'(card_suit_o), mon_e.suit);
            check("card_points", int'(card_points_o), mon_e.pts);
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Issue one draw, queue its expected card, and measure cycles to card_valid_o.
   task automatic do_draw(input logic [7:0] s, input int id, input int rank, input int suit,
                          input int pts, input int lat);
      int n;
      exp_q.push_back('{id, rank, suit, pts});
      @(posedge clk);
      #1;
      seed = s;
      draw = 1'b1;
      @(posedge clk);
      #1 draw = 1'b0;
      n = 0;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (card_valid_o) begin
            n = k;
            k = 81;
         end
      end
      check("draw_latency", n, lat);
   endtask

   task automatic pulse_shuffle();
      @(posedge clk);
      #1 shuffle = 1'b1;
      @(posedge clk);
      #1 shuffle = 1'b0;
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      check("rst_busy", int'(busy_o), 0);
      check("rst_cards_left", int'(cards_left_o), 52);
      check("rst_valid", int'(card_valid_o), 0);
      check("rst_card_id", int'(card_id_o), 0);
      check("rst_deck_empty", int'(deck_empty_o), 0);
      check("rst_draw_err", int'(draw_err_o), 0);

`ifdef SEED_RANDOM_1_DEALER_BURN_EN
      do_draw(8'd0, 1, 2, 0, 2, 3);
      check("burn_left", int'(cards_left_o), 50);
      do_draw(8'd0, 2, 3, 0, 3, 4);
      check("noburn_left", int'(cards_left_o), 49);
      pulse_shuffle();
      do_draw(8'd0, 1, 2, 0, 2, 3);
      check("burn_after_shuffle_left", int'(cards_left_o), 50);
`else
      // Seeded draws, linear probing and wrap
      do_draw(8'd0, 0, 1, 0, 1, 2);
      check("t1_left", int'(cards_left_o), 51);
      do_draw(8'd0, 1, 2, 0, 2, 3);
      do_draw(8'd52, 2, 3, 0, 3, 4);
      do_draw(8'd51, 51, 13, 3, 10, 2);
      do_draw(8'd51, 3, 4, 0, 4, 6);
      do_draw(8'd36, 36, 11, 2, 10, 2);
      check("t3_left", int'(cards_left_o), 46);

      // Full deck from seed 10, then empty-deck draw
      do_reset();
      for (int i = 0; i < 52; i++) begin
         int id;
         id = (10 + i) % 52;
         do_draw(8'd10, id, (id % 13) + 1, id / 13, ((id % 13) + 1 > 10) ? 10 : (id % 13) + 1, i + 2);
      end
      @(negedge clk);
      check("t4_deck_empty", int'(deck_empty_o), 1);
      check("t4_left", int'(cards_left_o), 0);
      @(posedge clk);
      #1 draw = 1'b1;
      @(posedge clk);
      #1 draw = 1'b0;
      @(negedge clk);
      check("t4_draw_err", int'(draw_err_o), 1);
      check("t4_busy", int'(busy_o), 0);
      @(negedge clk);
      check("t4_draw_err_pulse", int'(draw_err_o), 0);

      // Shuffles: in IDLE, during PROBE, and together with a draw
      pulse_shuffle();
      @(negedge clk);
      check("t5_shuffle_left", int'(cards_left_o), 52);
      check("t5_shuffle_empty", int'(deck_empty_o), 0);
      exp_q.push_back('{5, 6, 0, 6});
      @(posedge clk);
      #1;
      seed = 8'd5;
      draw = 1'b1;
      @(posedge clk);
      #1;
      draw = 1'b0;
      shuffle = 1'b1;
      @(posedge clk);
      #1 shuffle = 1'b0;
      @(negedge clk);
      check("t5_probe_shuffle_valid", int'(card_valid_o), 1);
      check("t5_probe_shuffle_left", int'(cards_left_o), 51);
      @(posedge clk);
      @(negedge clk);
      check("t5_idle_busy", int'(busy_o), 0);
      check("t5_idle_left", int'(cards_left_o), 51);
      @(posedge clk);
      @(negedge clk);
      check("t5_pending_applied", int'(cards_left_o), 52);
      do_draw(8'd7, 7, 8, 0, 8, 2);
      check("t5_pre_left", int'(cards_left_o), 51);
      @(posedge clk);
      #1;
      draw = 1'b1;
      shuffle = 1'b1;
      @(posedge clk);
      #1;
      draw = 1'b0;
      shuffle = 1'b0;
      @(negedge clk);
      check("t5_both_left", int'(cards_left_o), 52);
      check("t5_both_busy", int'(busy_o), 0);
      @(negedge clk);
      check("t5_both_valid", int'(card_valid_o), 0);

      // Reset during PROBE
      @(posedge clk);
      #1;
      seed = 8'd0;
      draw = 1'b1;
      @(posedge clk);
      #1;
      draw = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t6_busy", int'(busy_o), 0);
      check("t6_left", int'(cards_left_o), 52);
      check("t6_valid", int'(card_valid_o), 0);
      check("t6_card_id", int'(card_id_o), 0);
      check("t6_rank", int'(card_rank_o), 0);
      check("t6_suit", int'(card_suit_o), 0);
      check("t6_points", int'(card_points_o), 0);
      @(negedge clk);
      check("t6_busy_after", int'(busy_o), 0);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
